pipe_latch_gen: RTL and testbench

Parametrised inter-stage pipeline latch: the successor to the hand-written per-stage latches. It carries a packed stage record of WIDTH bits through DEPTH back-to-back register slots, each with its own valid bit. The hazard unit drives global stall, per-slot flush and bubble insertion. It sits between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB), and DEPTH>1 covers multi-cycle stages.

---
 rtl/pipe_latch_gen_pkg.sv | 25 ++
 rtl/pipe_latch_gen_if.sv | 45 ++++
 rtl/pipe_slot.sv | 58 +++++
 rtl/pipe_latch_gen.sv | 103 ++++++++++
 tb/tb_pipe_latch_gen.sv | 355 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_latch_gen_pkg.sv
// pipe_latch_gen_pkg
// Shared pipeline types: per-stage record typedefs, their NOP constants,
// counter width and the occupancy-width helper used by the latch and its
// interface.
package pipe_latch_gen_pkg;

    // ID/EX stage record; the latch WIDTH defaults to $bits of this record.
    typedef struct packed {
        logic [6:0] opcode;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [9:0] imm;
    } id_ex_rec_t;

    localparam int         REC_W     = $bits(id_ex_rec_t);
    localparam id_ex_rec_t ID_EX_NOP = '0;
    localparam int         CNT_W     = 32;

    // Bits needed to count 0..depth valid slots.
    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pipe_latch_gen_if.sv
// pipe_latch_gen_if
// Bundles the upstream record, hazard-unit controls and latch status.
//   master : upstream stage / hazard unit (drives in_data, in_valid, stall,
//            bubble, flush; observes out_*, busy, occupancy, counters)
//   slave  : the pipeline latch
// PIPE_PERF_CNT_EN adds the stall_cnt / kill_cnt status signals.
interface pipe_latch_gen_if
    import pipe_latch_gen_pkg::*;
#(
    parameter int WIDTH = REC_W,
    parameter int DEPTH = 1
) ();
    localparam int OCC_W = occ_width(DEPTH);

    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             stall;
    logic             bubble;
    logic [DEPTH-1:0] flush;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             busy;
    logic [OCC_W-1:0] occupancy;
`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] kill_cnt;
`endif

    modport master (
        output in_data, in_valid, stall, bubble, flush,
`ifdef PIPE_PERF_CNT_EN
        input  stall_cnt, kill_cnt,
`endif
        input  out_data, out_valid, busy, occupancy
    );

    modport slave (
        input  in_data, in_valid, stall, bubble, flush,
`ifdef PIPE_PERF_CNT_EN
        output stall_cnt, kill_cnt,
`endif
        output out_data, out_valid, busy, occupancy
    );

endinterface

// File: rtl/pipe_slot.sv
// pipe_slot
// One data+valid register of the pipeline latch.
// Next-state priority: flush > stall (hold) > bubble (first slot only) > load.
//   clk, rst      : clock, asynchronous active-high reset
//   flush_i       : kill this slot (wins over stall)
//   stall_i       : hold this slot
//   bubble_i      : load NOP (honoured only when FIRST=1)
//   src_data_i/src_valid_i : upstream record
//   data_o/valid_o         : slot contents
module pipe_slot #(
    parameter int               WIDTH   = 32,
    parameter logic [WIDTH-1:0] NOP_VAL = '0,
    parameter bit               FIRST   = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             stall_i,
    input  logic             bubble_i,
    input  logic [WIDTH-1:0] src_data_i,
    input  logic             src_valid_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o
);
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (flush_i) begin
            data_d  = NOP_VAL;
            valid_d = 1'b0;
        end else if (!stall_i) begin
            if (FIRST && bubble_i) begin
                data_d  = NOP_VAL;
                valid_d = 1'b0;
            end else begin
                data_d  = src_data_i;
                valid_d = src_valid_i;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= NOP_VAL;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/pipe_latch_gen.sv
// pipe_latch_gen
// Parametrised inter-stage pipeline latch: DEPTH chained pipe_slot registers
// carrying a WIDTH-bit stage record with per-slot valid.
//   CLK  : rising-edge clock
//   RST  : asynchronous active-high reset
//   pipe : pipe_latch_gen_if.slave (in_data/in_valid, stall, bubble,
//          flush[DEPTH], out_data/out_valid, busy, occupancy)
// Optional macro PIPE_PERF_CNT_EN adds saturating stall_cnt / kill_cnt.
module pipe_latch_gen
    import pipe_latch_gen_pkg::*;
#(
    parameter int               WIDTH   = REC_W,
    parameter int               DEPTH   = 1,
    parameter logic [WIDTH-1:0] NOP_VAL = '0
) (
    input  logic             CLK,
    input  logic             RST,
    pipe_latch_gen_if.slave  pipe
);
    localparam int OCC_W = occ_width(DEPTH);

    logic [WIDTH-1:0] slot_data [DEPTH];
    logic [DEPTH-1:0] slot_valid;
    logic [OCC_W-1:0] occ;

    genvar g;
    for (g = 0; g < DEPTH; g++) begin : g_slot
        logic [WIDTH-1:0] src_data;
        logic             src_valid;

        if (g == 0) begin : g_head
            assign src_data  = pipe.in_data;
            assign src_valid = pipe.in_valid;
        end else begin : g_tail
            assign src_data  = slot_data[g-1];
            assign src_valid = slot_valid[g-1];
        end

        pipe_slot #(
            .WIDTH   (WIDTH),
            .NOP_VAL (NOP_VAL),
            .FIRST   (g == 0)
        ) u_slot (
            .clk         (CLK),
            .rst         (RST),
            .flush_i     (pipe.flush[g]),
            .stall_i     (pipe.stall),
            .bubble_i    (pipe.bubble),
            .src_data_i  (src_data),
            .src_valid_i (src_valid),
            .data_o      (slot_data[g]),
            .valid_o     (slot_valid[g])
        );
    end

    always_comb begin
        occ = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            occ = occ + OCC_W'(slot_valid[i]);
        end
    end

    assign pipe.out_data  = slot_data[DEPTH-1];
    assign pipe.out_valid = slot_valid[DEPTH-1];
    assign pipe.busy      = |slot_valid;
    assign pipe.occupancy = occ;

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] kill_cnt_q, kill_cnt_d;
    logic [OCC_W-1:0] kills;
    logic [CNT_W:0]   kill_sum;

    // Kills count slots that held valid work when their flush bit was set;
    // the extra sum bit detects overflow so the counter sticks at all-ones.
    always_comb begin
        kills = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            kills = kills + OCC_W'(pipe.flush[i] & slot_valid[i]);
        end
        stall_cnt_d = stall_cnt_q;
        if (pipe.stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        kill_sum   = {1'b0, kill_cnt_q} + (CNT_W+1)'(kills);
        kill_cnt_d = kill_sum[CNT_W] ? '1 : kill_sum[CNT_W-1:0];
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stall_cnt_q <= '0;
            kill_cnt_q  <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            kill_cnt_q  <= kill_cnt_d;
        end
    end

    assign pipe.stall_cnt = stall_cnt_q;
    assign pipe.kill_cnt  = kill_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_latch_gen.sv
// tb_pipe_latch_gen
// Drives DEPTH=3, DEPTH=2 and DEPTH=1 latches with identical stimulus and
// compares them with an array-based reference of the slot rules, plus
// directed scenarios with fixed expected values.
module tb_pipe_latch_gen;
    localparam int W = 32;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    pipe_latch_gen_if #(.WIDTH(W), .DEPTH(3)) if3 ();
    pipe_latch_gen_if #(.WIDTH(W), .DEPTH(2)) if2 ();
    pipe_latch_gen_if #(.WIDTH(W), .DEPTH(1)) if1 ();

    pipe_latch_gen #(.WIDTH(W), .DEPTH(3)) dut3 (.CLK(CLK), .RST(RST), .pipe(if3));
    pipe_latch_gen #(.WIDTH(W), .DEPTH(2)) dut2 (.CLK(CLK), .RST(RST), .pipe(if2));
    pipe_latch_gen #(.WIDTH(W), .DEPTH(1)) dut1 (.CLK(CLK), .RST(RST), .pipe(if1));

    // Shared stimulus
    logic [W-1:0] s_data;
    logic         s_valid, s_stall, s_bubble;
    logic [2:0]   f3;
    logic [1:0]   f2;
    logic         f1;

    assign if3.in_data = s_data;  assign if3.in_valid = s_valid;
    assign if3.stall   = s_stall; assign if3.bubble   = s_bubble; assign if3.flush = f3;
    assign if2.in_data = s_data;  assign if2.in_valid = s_valid;
    assign if2.stall   = s_stall; assign if2.bubble   = s_bubble; assign if2.flush = f2;
    assign if1.in_data = s_data;  assign if1.in_valid = s_valid;
    assign if1.stall   = s_stall; assign if1.bubble   = s_bubble; assign if1.flush = f1;

    // Outputs gathered per instance (0: DEPTH3, 1: DEPTH2, 2: DEPTH1)
    logic [W-1:0] od_a [3];
    logic         ov_a [3];
    logic         bz_a [3];
    logic [3:0]   oc_a [3];
    assign od_a[0] = if3.out_data; assign ov_a[0] = if3.out_valid;
    assign bz_a[0] = if3.busy;     assign oc_a[0] = 4'(if3.occupancy);
    assign od_a[1] = if2.out_data; assign ov_a[1] = if2.out_valid;
    assign bz_a[1] = if2.busy;     assign oc_a[1] = 4'(if2.occupancy);
    assign od_a[2] = if1.out_data; assign ov_a[2] = if1.out_valid;
    assign bz_a[2] = if1.busy;     assign oc_a[2] = 4'(if1.occupancy);
`ifdef PIPE_PERF_CNT_EN
    logic [31:0] sc_a [3];
    logic [31:0] kc_a [3];
    assign sc_a[0] = if3.stall_cnt; assign kc_a[0] = if3.kill_cnt;
    assign sc_a[1] = if2.stall_cnt; assign kc_a[1] = if2.kill_cnt;
    assign sc_a[2] = if1.stall_cnt; assign kc_a[2] = if1.kill_cnt;
`endif

    // Reference model
    int           dep [3] = '{3, 2, 1};
    logic [W-1:0] m_d [3][8];
    logic         m_v [3][8];
    longint       m_sc [3];
    longint       m_kc [3];

    int checks = 0;
    int errors = 0;

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 8; i++) begin
                m_d[k][i] = '0;
                m_v[k][i] = 1'b0;
            end
            m_sc[k] = 0;
            m_kc[k] = 0;
        end
    endtask

    function automatic int m_occ(input int k);
        int n = 0;
        for (int i = 0; i < dep[k]; i++) n += int'(m_v[k][i]);
        return n;
    endfunction

    // One clock edge with the current stimulus; model follows the slot rules.
    task automatic tick();
        logic [W-1:0] pd [3][8];
        logic         pv [3][8];
        logic [7:0]   fl;
        int           nk;
        @(posedge CLK);
        pd = m_d;
        pv = m_v;
        for (int k = 0; k < 3; k++) begin
            fl = (k == 0) ? 8'(f3) : (k == 1) ? 8'(f2) : 8'(f1);
            nk = 0;
            for (int i = 0; i < dep[k]; i++) begin
                if (fl[i] && pv[k][i]) nk++;
                if (fl[i]) begin
                    m_d[k][i] = '0;
                    m_v[k][i] = 1'b0;
                end else if (!s_stall) begin
                    if (s_bubble && i == 0) begin
                        m_d[k][i] = '0;
                        m_v[k][i] = 1'b0;
                    end else if (i == 0) begin
                        m_d[k][i] = s_data;
                        m_v[k][i] = s_valid;
                    end else begin
                        m_d[k][i] = pd[k][i-1];
                        m_v[k][i] = pv[k][i-1];
                    end
                end
            end
            if (s_stall) m_sc[k] = m_sc[k] + 1;
            m_kc[k] = m_kc[k] + nk;
            if (m_sc[k] > 64'hFFFF_FFFF) m_sc[k] = 64'hFFFF_FFFF;
            if (m_kc[k] > 64'hFFFF_FFFF) m_kc[k] = 64'hFFFF_FFFF;
        end
        #1;
    endtask

    task automatic idle_inputs();
        s_data = '0; s_valid = 1'b0; s_stall = 1'b0; s_bubble = 1'b0;
        f3 = '0; f2 = '0; f1 = 1'b0;
    endtask

    task automatic feed(input logic [W-1:0] d);
        s_data = d; s_valid = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        RST = 1'b1;
        model_reset();
        repeat (3) @(posedge CLK);
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (ov_a[k] !== 1'b0 || od_a[k] !== '0 || oc_a[k] !== 4'd0 || bz_a[k] !== 1'b0) begin
                errors++;
                $display("FAIL reset[%0d]: got valid=%b data=%h occ=%0d busy=%b required 0/0/0/0",
                         k, ov_a[k], od_a[k], oc_a[k], bz_a[k]);
            end
`ifdef PIPE_PERF_CNT_EN
            checks++;
            if (sc_a[k] !== 32'd0 || kc_a[k] !== 32'd0) begin
                errors++;
                $display("FAIL reset_cnt[%0d]: got stall=%0d kill=%0d required 0/0", k, sc_a[k], kc_a[k]);
            end
`endif
        end
        #3 RST = 1'b0;
    endtask

    task automatic test_pipeline();
        idle_inputs();
        feed(32'hA1); feed(32'hA2); feed(32'hA3);
        checks++;
        if (if3.out_data !== 32'hA1 || if3.out_valid !== 1'b1 || if3.occupancy !== 2'd3) begin
            errors++;
            $display("FAIL pipeline_c3: got data=%h valid=%b occ=%0d required A1/1/3",
                     if3.out_data, if3.out_valid, if3.occupancy);
        end
        s_valid = 1'b0; s_data = '0;
        tick();
        checks++;
        if (if3.out_data !== 32'hA2) begin
            errors++;
            $display("FAIL pipeline_c4: got %h required a2", if3.out_data);
        end
        tick();
        checks++;
        if (if3.out_data !== 32'hA3 || if3.occupancy !== 2'd1) begin
            errors++;
            $display("FAIL pipeline_c5: got data=%h occ=%0d required a3/1", if3.out_data, if3.occupancy);
        end
    endtask

    task automatic test_async_reset();
        idle_inputs();
        feed(32'h11); feed(32'h12); feed(32'h13);
        checks++;
        if (if3.occupancy !== 2'd3) begin
            errors++;
            $display("FAIL async_pre_occ: got %0d required 3", if3.occupancy);
        end
        #2 RST = 1'b1;
        #1;
        model_reset();
        checks++;
        if (if3.out_valid !== 1'b0 || if3.out_data !== '0 || if3.occupancy !== 2'd0 || if3.busy !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got valid=%b data=%h occ=%0d busy=%b required 0/0/0/0",
                     if3.out_valid, if3.out_data, if3.occupancy, if3.busy);
        end
        #1 RST = 1'b0;
        feed(32'h21);
        checks++;
        if (if1.out_data !== 32'h21 || if1.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL async_first_capture: got data=%h valid=%b required 21/1", if1.out_data, if1.out_valid);
        end
    endtask

    task automatic test_stall();
        idle_inputs();
        feed(32'hB2); feed(32'hB1);
        s_stall = 1'b1; s_data = 32'hC0; s_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++;
            if (if2.out_data !== 32'hB2 || if2.out_valid !== 1'b1) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got data=%h valid=%b required b2/1", c, if2.out_data, if2.out_valid);
            end
        end
`ifdef PIPE_PERF_CNT_EN
        checks++;
        if (longint'(if2.stall_cnt) !== m_sc[1]) begin
            errors++;
            $display("FAIL stall_cnt: got %0d required %0d", if2.stall_cnt, m_sc[1]);
        end
`endif
        s_stall = 1'b0; s_valid = 1'b0;
        tick();
        checks++;
        if (if2.out_data !== 32'hB1) begin
            errors++;
            $display("FAIL stall_release: got %h required b1", if2.out_data);
        end
    endtask

    task automatic test_flush_stall();
        idle_inputs();
        feed(32'hC1); feed(32'hC2); feed(32'hC3);
        s_valid = 1'b0; s_stall = 1'b1; f3 = 3'b011;
        tick();
        checks++;
        if (if3.out_data !== 32'hC1 || if3.out_valid !== 1'b1 || if3.occupancy !== 2'd1) begin
            errors++;
            $display("FAIL flush_stall: got data=%h valid=%b occ=%0d required c1/1/1",
                     if3.out_data, if3.out_valid, if3.occupancy);
        end
`ifdef PIPE_PERF_CNT_EN
        checks++;
        if (longint'(if3.kill_cnt) !== m_kc[0]) begin
            errors++;
            $display("FAIL kill_cnt: got %0d required %0d", if3.kill_cnt, m_kc[0]);
        end
`endif
        s_stall = 1'b0; f3 = '0;
        tick();
        checks++;
        if (if3.out_valid !== 1'b0 || if3.out_data !== '0) begin
            errors++;
            $display("FAIL flush_drain: got data=%h valid=%b required 0/0", if3.out_data, if3.out_valid);
        end
    endtask

    task automatic test_bubble();
        idle_inputs();
        feed(32'hE1); feed(32'hE0);
        s_data = 32'hD0; s_valid = 1'b1; s_bubble = 1'b1;
        tick();
        checks++;
        if (if2.out_data !== 32'hE0 || if2.out_valid !== 1'b1 || if2.occupancy !== 2'd1) begin
            errors++;
            $display("FAIL bubble_d2: got data=%h valid=%b occ=%0d required e0/1/1",
                     if2.out_data, if2.out_valid, if2.occupancy);
        end
        checks++;
        if (if1.out_valid !== 1'b0 || if1.out_data !== '0) begin
            errors++;
            $display("FAIL bubble_d1: got data=%h valid=%b required 0/0", if1.out_data, if1.out_valid);
        end
        s_stall = 1'b1;
        tick();
        checks++;
        if (if2.out_data !== 32'hE0 || if2.out_valid !== 1'b1 || if2.occupancy !== 2'd1) begin
            errors++;
            $display("FAIL bubble_stall: got data=%h valid=%b occ=%0d required e0/1/1",
                     if2.out_data, if2.out_valid, if2.occupancy);
        end
    endtask

    task automatic test_random();
        int r;
        logic [2:0] m;
        idle_inputs();
        for (int c = 0; c < 400; c++) begin
            s_data   = $urandom;
            s_valid  = ($urandom_range(0, 3) != 0);
            s_stall  = ($urandom_range(0, 3) == 0);
            s_bubble = ($urandom_range(0, 4) == 0);
            r = $urandom_range(0, 99);
            if (r < 12)      m = 3'((1 << $urandom_range(1, 3)) - 1);
            else if (r < 18) m = 3'($urandom);
            else             m = 3'b000;
            f3 = m; f2 = m[1:0]; f1 = m[0];
            tick();
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (od_a[k] !== m_d[k][dep[k]-1] || ov_a[k] !== m_v[k][dep[k]-1] ||
                    oc_a[k] !== 4'(m_occ(k)) || bz_a[k] !== (m_occ(k) != 0)) begin
                    errors++;
                    $display("FAIL random[%0d] inst%0d: got data=%h valid=%b occ=%0d busy=%b required %h/%b/%0d/%b",
                             c, k, od_a[k], ov_a[k], oc_a[k], bz_a[k],
                             m_d[k][dep[k]-1], m_v[k][dep[k]-1], m_occ(k), (m_occ(k) != 0));
                end
`ifdef PIPE_PERF_CNT_EN
                checks++;
                if (longint'(sc_a[k]) !== m_sc[k] || longint'(kc_a[k]) !== m_kc[k]) begin
                    errors++;
                    $display("FAIL random_cnt[%0d] inst%0d: got stall=%0d kill=%0d required %0d/%0d",
                             c, k, sc_a[k], kc_a[k], m_sc[k], m_kc[k]);
                end
`endif
            end
        end
    endtask

`ifdef PIPE_PERF_CNT_EN
    task automatic test_saturation();
        idle_inputs();
        force dut3.stall_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut3.stall_cnt_q;
        m_sc[0] = 64'hFFFF_FFFE;
        s_stall = 1'b1;
        repeat (3) tick();
        checks++;
        if (if3.stall_cnt !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL stall_cnt_sat: got %h required ffffffff", if3.stall_cnt);
        end
        s_stall = 1'b0;
    endtask
`endif

    initial begin
        idle_inputs();
        RST = 1'b0;
        model_reset();
        test_reset();
        test_pipeline();
        test_async_reset();
        test_stall();
        test_flush_stall();
        test_bubble();
        test_random();
`ifdef PIPE_PERF_CNT_EN
        test_saturation();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
